// File: rtl/add_sub_33_reg.sv
// Registered 33-bit adder/subtractor: A+B and A-B with carry-out, one-cycle latency.
// Optional signed-overflow outputs Ovf_add/Ovf_sub are built when ADD_SUB_33_OVF_EN is defined.
module add_sub_33_reg #(
    parameter int WIDTH = 33,
    parameter int BLK_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] S_add,
    output logic             Cout_add,
    output logic [WIDTH-1:0] S_sub,
    output logic             Cout_sub
`ifdef ADD_SUB_33_OVF_EN
    ,
    output logic             Ovf_add,
    output logic             Ovf_sub
`endif
);

    localparam int NBLK = (WIDTH + BLK_W - 1) / BLK_W;

    // Two-level carry lookahead; returns {carry_out, sum}.
    function automatic logic [WIDTH:0] cla_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] sum;
        logic [WIDTH:0]   c;
        logic [NBLK-1:0]  bg;
        logic [NBLK-1:0]  bp;
        logic [NBLK:0]    bc;
        logic             pre;
        logic             ci;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < NBLK; k++) begin
            bg[k] = 1'b0;
            bp[k] = 1'b1;
            for (int i = 0; i < BLK_W; i++) begin
                if (k * BLK_W + i < WIDTH) begin
                    bg[k] = g[k*BLK_W+i] | (p[k*BLK_W+i] & bg[k]);
                    bp[k] = bp[k] & p[k*BLK_W+i];
                end
            end
        end
        // Each block carry is a flat sum-of-products over all lower blocks.
        bc[0] = cin;
        for (int k = 0; k < NBLK; k++) begin
            bc[k+1] = bg[k];
            pre     = bp[k];
            for (int j = k - 1; j >= 0; j--) begin
                bc[k+1] = bc[k+1] | (pre & bg[j]);
                pre     = pre & bp[j];
            end
            bc[k+1] = bc[k+1] | (pre & cin);
        end
        c[0] = cin;
        for (int idx = 0; idx < WIDTH; idx++) begin
            ci         = ((idx % BLK_W) == 0) ? bc[idx/BLK_W] : c[idx];
            sum[idx]   = p[idx] ^ ci;
            c[idx+1]   = g[idx] | (p[idx] & ci);
        end
        return {c[WIDTH], sum};
    endfunction

    logic [WIDTH:0]   add_res;
    logic [WIDTH:0]   sub_res;
    logic [WIDTH-1:0] b_inv;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_add_q, s_add_d;
    logic [WIDTH-1:0] s_sub_q, s_sub_d;
    logic             cout_add_q, cout_add_d;
    logic             cout_sub_q, cout_sub_d;
`ifdef ADD_SUB_33_OVF_EN
    logic             ovf_add_q, ovf_add_d;
    logic             ovf_sub_q, ovf_sub_d;
    logic             cin_msb_add;
    logic             cin_msb_sub;
`endif

    always_comb begin
        b_inv   = ~B;
        add_res = cla_add(A, B, 1'b0);
        sub_res = cla_add(A, b_inv, 1'b1);
    end

`ifdef ADD_SUB_33_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        cin_msb_add = add_res[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1];
        cin_msb_sub = sub_res[WIDTH-1] ^ A[WIDTH-1] ^ b_inv[WIDTH-1];
    end
`endif

    always_comb begin
        out_valid_d = in_valid;
        s_add_d     = s_add_q;
        s_sub_d     = s_sub_q;
        cout_add_d  = cout_add_q;
        cout_sub_d  = cout_sub_q;
`ifdef ADD_SUB_33_OVF_EN
        ovf_add_d   = ovf_add_q;
        ovf_sub_d   = ovf_sub_q;
`endif
        if (in_valid) begin
            s_add_d    = add_res[WIDTH-1:0];
            cout_add_d = add_res[WIDTH];
            s_sub_d    = sub_res[WIDTH-1:0];
            cout_sub_d = sub_res[WIDTH];
`ifdef ADD_SUB_33_OVF_EN
            ovf_add_d  = cin_msb_add ^ add_res[WIDTH];
            ovf_sub_d  = cin_msb_sub ^ sub_res[WIDTH];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            s_add_q     <= '0;
            s_sub_q     <= '0;
            cout_add_q  <= 1'b0;
            cout_sub_q  <= 1'b0;
`ifdef ADD_SUB_33_OVF_EN
            ovf_add_q   <= 1'b0;
            ovf_sub_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            s_add_q     <= s_add_d;
            s_sub_q     <= s_sub_d;
            cout_add_q  <= cout_add_d;
            cout_sub_q  <= cout_sub_d;
`ifdef ADD_SUB_33_OVF_EN
            ovf_add_q   <= ovf_add_d;
            ovf_sub_q   <= ovf_sub_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign S_add     = s_add_q;
    assign S_sub     = s_sub_q;
    assign Cout_add  = cout_add_q;
    assign Cout_sub  = cout_sub_q;
`ifdef ADD_SUB_33_OVF_EN
    assign Ovf_add   = ovf_add_q;
    assign Ovf_sub   = ovf_sub_q;
`endif

endmodule

// File: tb/tb_add_sub_33_reg.sv
// Self-checking bench for add_sub_33_reg: directed corner cases plus random back-to-back vectors
// against an arithmetic reference model.
module tb_add_sub_33_reg;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [32:0] A;
    logic [32:0] B;
    logic        out_valid;
    logic [32:0] S_add;
    logic        Cout_add;
    logic [32:0] S_sub;
    logic        Cout_sub;
`ifdef ADD_SUB_33_OVF_EN
    logic        Ovf_add;
    logic        Ovf_sub;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference model state: what the outputs must show after the current edge.
    logic        e_valid;
    logic [32:0] e_add;
    logic        e_cadd;
    logic [32:0] e_sub;
    logic        e_csub;
    logic        e_oadd;
    logic        e_osub;

    add_sub_33_reg dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .S_add    (S_add),
        .Cout_add (Cout_add),
        .S_sub    (S_sub),
        .Cout_sub (Cout_sub)
`ifdef ADD_SUB_33_OVF_EN
        ,
        .Ovf_add  (Ovf_add),
        .Ovf_sub  (Ovf_sub)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        check({tag, ".S_add"}, 64'(S_add), 64'(e_add));
        check({tag, ".Cout_add"}, 64'(Cout_add), 64'(e_cadd));
        check({tag, ".S_sub"}, 64'(S_sub), 64'(e_sub));
        check({tag, ".Cout_sub"}, 64'(Cout_sub), 64'(e_csub));
`ifdef ADD_SUB_33_OVF_EN
        check({tag, ".Ovf_add"}, 64'(Ovf_add), 64'(e_oadd));
        check({tag, ".Ovf_sub"}, 64'(Ovf_sub), 64'(e_osub));
`endif
    endtask

    // Plain integer arithmetic; signed overflow from operand/result signs.
    task automatic model(input logic r, input logic v, input logic [32:0] a, input logic [32:0] b);
        logic [33:0] wide;
        if (r) begin
            e_valid = 0; e_add = 0; e_cadd = 0; e_sub = 0; e_csub = 0; e_oadd = 0; e_osub = 0;
        end else begin
            e_valid = v;
            if (v) begin
                wide   = {1'b0, a} + {1'b0, b};
                e_add  = wide[32:0];
                e_cadd = wide[33];
                e_sub  = a - b;
                e_csub = (a >= b);
                e_oadd = (a[32] == b[32]) && (e_add[32] != a[32]);
                e_osub = (a[32] != b[32]) && (e_sub[32] != a[32]);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [32:0] a, input logic [32:0] b);
        reset = r; in_valid = v; A = a; B = b;
        @(posedge clock);
        #1;
        model(r, v, a, b);
        check_all(tag);
    endtask

    initial begin
        e_oadd = 0;
        e_osub = 0;
        reset = 1; in_valid = 0; A = 0; B = 0;
        step("reset0", 1, 0, 33'd0, 33'd0);
        step("reset1", 1, 1, 33'h1_2345_6789, 33'h0_1111_1111);

        step("maxp1", 0, 1, 33'h1_FFFF_FFFF, 33'h0_0000_0001);
        check("maxp1.lit_S_sub", 64'(S_sub), 64'h1_FFFF_FFFE);
        check("maxp1.lit_Cout_add", 64'(Cout_add), 64'd1);
        step("zm1", 0, 1, 33'd0, 33'd1);
        check("zm1.lit_S_sub", 64'(S_sub), 64'h1_FFFF_FFFF);
        check("zm1.lit_Cout_sub", 64'(Cout_sub), 64'd0);
        step("maxmax", 0, 1, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF);
        check("maxmax.lit_S_add", 64'(S_add), 64'h1_FFFF_FFFE);
        step("zero", 0, 1, 33'd0, 33'd0);
        check("zero.lit_Cout_sub", 64'(Cout_sub), 64'd1);
        step("eq", 0, 1, 33'h0_DEAD_BEEF, 33'h0_DEAD_BEEF);
        step("blkc", 0, 1, 33'h0_00FF_FFFF, 33'h0_0000_0001);

        // Hold with undriven operands.
        step("hold0", 0, 0, 'x, 'x);
        step("hold1", 0, 0, 'x, 'x);
        step("hold2", 0, 0, 33'h1_5555_AAAA, 33'h0_1234_5678);
        step("rst_ovr", 1, 1, 33'h1_0F0F_0F0F, 33'h0_F0F0_F0F0);
        check("rst_ovr.lit_out_valid", 64'(out_valid), 64'd0);

`ifdef ADD_SUB_33_OVF_EN
        step("ovf_a", 0, 1, 33'h0_FFFF_FFFF, 33'd1);
        check("ovf_a.lit_Ovf_add", 64'(Ovf_add), 64'd1);
        check("ovf_a.lit_Ovf_sub", 64'(Ovf_sub), 64'd0);
        step("ovf_b", 0, 1, 33'h1_0000_0000, 33'd1);
        check("ovf_b.lit_Ovf_add", 64'(Ovf_add), 64'd0);
        check("ovf_b.lit_Ovf_sub", 64'(Ovf_sub), 64'd1);
`endif

        for (int i = 0; i < 24; i++) begin
            logic [32:0] ra;
            logic [32:0] rb;
            logic        rv;
            ra = {$urandom_range(0, 1) == 1, $urandom()};
            rb = {$urandom_range(0, 1) == 1, $urandom()};
            rv = (i < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step($sformatf("rand%0d", i), 0, rv, ra, rb);
        end

        step("rst_mid", 1, 1, 33'h0_1357_9BDF, 33'h1_0246_8ACE);
        step("post_rst", 0, 1, 33'h1_8000_0000, 33'h1_8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
